// File: rtl/wbs_ctrl_pkg.sv
// Shared definitions for the Wishbone slave controller: region codes,
// register addresses, FSM states and the address-region decoder.
package wbs_ctrl_pkg;

  localparam logic [7:0] RGN_REGS  = 8'h30;
  localparam logic [7:0] RGN_QUERY = 8'h31;
  localparam logic [7:0] RGN_LEAF  = 8'h32;
  localparam logic [7:0] RGN_BEST  = 8'h33;
  localparam logic [7:0] RGN_NODE  = 8'h34;

  localparam logic [31:0] ADR_MODE  = 32'h3000_0000;
  localparam logic [31:0] ADR_DEBUG = 32'h3000_0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_ACK
  } state_e;

  typedef enum logic [2:0] {
    RG_REGS,
    RG_QUERY,
    RG_LEAF,
    RG_BEST,
    RG_NODE,
    RG_NONE
  } region_e;

  // Map the top address byte onto a region
  function automatic region_e decode_region(input logic [7:0] code);
    case (code)
      RGN_REGS:  return RG_REGS;
      RGN_QUERY: return RG_QUERY;
      RGN_LEAF:  return RG_LEAF;
      RGN_BEST:  return RG_BEST;
      RGN_NODE:  return RG_NODE;
      default:   return RG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wbs_ctrl.sv
// Wishbone slave bridging bus accesses onto config registers and the
// query-patch, leaf and node memories; fixed four-state access sequence.
module wbs_ctrl
  import wbs_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned LEAF_SIZE  = 8,
  parameter int unsigned PATCH_SIZE = 5,
  parameter int unsigned ROW_SIZE   = 24,
  parameter int unsigned COL_SIZE   = 17,
  parameter int unsigned K          = 4,
  parameter int unsigned NUM_LEAVES = 64,
  localparam int unsigned QW = $clog2(ROW_SIZE * COL_SIZE),
  localparam int unsigned LW = $clog2(NUM_LEAVES),
  localparam int unsigned PW = PATCH_SIZE * DATA_WIDTH
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_dat_i,
  input  logic [31:0]                   wbs_adr_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  output logic                          wbs_mode,
  output logic                          wbs_debug,
  output logic                          wbs_qp_mem_csb0,
  output logic                          wbs_qp_mem_web0,
  output logic [QW-1:0]                 wbs_qp_mem_addr0,
  output logic [PW-1:0]                 wbs_qp_mem_wpatch0,
  input  logic [PW-1:0]                 wbs_qp_mem_rpatch0,
  output logic [LEAF_SIZE-1:0]          wbs_leaf_mem_csb0,
  output logic [LEAF_SIZE-1:0]          wbs_leaf_mem_web0,
  output logic [LW-1:0]                 wbs_leaf_mem_addr0,
  output logic [63:0]                   wbs_leaf_mem_wleaf0,
  input  logic [LEAF_SIZE-1:0][63:0]    wbs_leaf_mem_rleaf0,
  output logic                          wbs_node_mem_web,
  output logic [31:0]                   wbs_node_mem_addr,
  output logic [31:0]                   wbs_node_mem_wdata,
  input  logic [31:0]                   wbs_node_mem_rdata
);

  localparam int unsigned BW = $clog2(LEAF_SIZE);
  localparam int unsigned unused_k = K;

  // Byte-enables are ignored: every access is full-word
  logic unused_sel;
  assign unused_sel = ^wbs_sel_i;

  state_e state_q, state_d;

  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [31:0] qstage_q, qstage_d;
  logic [31:0] lstage_q, lstage_d;

  logic                 ack_d;
  logic [31:0]          dat_o_d;
  logic                 mode_d, debug_d;
  logic                 qp_csb_d, qp_web_d;
  logic [QW-1:0]        qp_addr_d;
  logic [PW-1:0]        qp_wpatch_d;
  logic [LEAF_SIZE-1:0] leaf_csb_d, leaf_web_d;
  logic [LW-1:0]        leaf_addr_d;
  logic [63:0]          leaf_wleaf_d;
  logic                 node_web_d;
  logic [31:0]          node_addr_d, node_wdata_d;

  region_e       rgn_in, rgn_q;
  logic [BW-1:0] bank_in, bank_q;
  logic [31:0]   rd_data;

  assign rgn_in  = decode_region(wbs_adr_i[31:24]);
  assign rgn_q   = decode_region(adr_q[31:24]);
  assign bank_in = wbs_adr_i[BW:1];
  assign bank_q  = adr_q[BW:1];

  // Read-data select for the captured request, sampled while in WAIT
  always_comb begin
    rd_data = '0;
    case (rgn_q)
      RG_REGS: begin
        if (adr_q == ADR_MODE)       rd_data = {31'b0, wbs_mode};
        else if (adr_q == ADR_DEBUG) rd_data = {31'b0, wbs_debug};
      end
      RG_QUERY: rd_data = adr_q[0] ? 32'(wbs_qp_mem_rpatch0[PW-1:32])
                                   : wbs_qp_mem_rpatch0[31:0];
      RG_LEAF:  rd_data = adr_q[0] ? wbs_leaf_mem_rleaf0[bank_q][63:32]
                                   : wbs_leaf_mem_rleaf0[bank_q][31:0];
      RG_NODE:  rd_data = wbs_node_mem_rdata;
      default:  rd_data = '0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    qstage_d     = qstage_q;
    lstage_d     = lstage_q;
    ack_d        = 1'b0;
    dat_o_d      = wbs_dat_o;
    mode_d       = wbs_mode;
    debug_d      = wbs_debug;
    qp_csb_d     = 1'b1;
    qp_web_d     = 1'b1;
    qp_addr_d    = wbs_qp_mem_addr0;
    qp_wpatch_d  = wbs_qp_mem_wpatch0;
    leaf_csb_d   = '1;
    leaf_web_d   = '1;
    leaf_addr_d  = wbs_leaf_mem_addr0;
    leaf_wleaf_d = wbs_leaf_mem_wleaf0;
    node_web_d   = 1'b0;
    node_addr_d  = wbs_node_mem_addr;
    node_wdata_d = wbs_node_mem_wdata;

    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          state_d = ST_ACCESS;
          adr_d   = wbs_adr_i;
          dat_d   = wbs_dat_i;
          we_d    = wbs_we_i;
          // Strobes are launched here so they are high throughout ACCESS
          case (rgn_in)
            RG_QUERY: begin
              if (!wbs_we_i || wbs_adr_i[0]) begin
                qp_csb_d  = 1'b0;
                qp_web_d  = !wbs_we_i;
                qp_addr_d = wbs_adr_i[QW:1];
                if (wbs_we_i) qp_wpatch_d = PW'({wbs_dat_i, qstage_q});
              end
            end
            RG_LEAF: begin
              if (!wbs_we_i || wbs_adr_i[0]) begin
                leaf_csb_d[bank_in] = 1'b0;
                leaf_web_d[bank_in] = !wbs_we_i;
                leaf_addr_d         = wbs_adr_i[BW+LW:BW+1];
                if (wbs_we_i) leaf_wleaf_d = {wbs_dat_i, lstage_q};
              end
            end
            RG_NODE: begin
              node_addr_d = {8'h00, wbs_adr_i[23:0]};
              if (wbs_we_i) begin
                node_web_d   = 1'b1;
                node_wdata_d = wbs_dat_i;
              end
            end
            default: ;
          endcase
        end
      end
      ST_ACCESS: begin
        state_d = ST_WAIT;
        if (we_q) begin
          case (rgn_q)
            RG_REGS: begin
              if (adr_q == ADR_MODE)       mode_d  = dat_q[0];
              else if (adr_q == ADR_DEBUG) debug_d = dat_q[0];
            end
            RG_QUERY: if (!adr_q[0]) qstage_d = dat_q;
            RG_LEAF:  if (!adr_q[0]) lstage_d = dat_q;
            default: ;
          endcase
        end
      end
      ST_WAIT: begin
        state_d = ST_ACK;
        ack_d   = 1'b1;
        dat_o_d = we_q ? 32'h0 : rd_data;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q             <= ST_IDLE;
      adr_q               <= '0;
      dat_q               <= '0;
      we_q                <= 1'b0;
      qstage_q            <= '0;
      lstage_q            <= '0;
      wbs_ack_o           <= 1'b0;
      wbs_dat_o           <= '0;
      wbs_mode            <= 1'b0;
      wbs_debug           <= 1'b0;
      wbs_qp_mem_csb0     <= 1'b1;
      wbs_qp_mem_web0     <= 1'b1;
      wbs_qp_mem_addr0    <= '0;
      wbs_qp_mem_wpatch0  <= '0;
      wbs_leaf_mem_csb0   <= '1;
      wbs_leaf_mem_web0   <= '1;
      wbs_leaf_mem_addr0  <= '0;
      wbs_leaf_mem_wleaf0 <= '0;
      wbs_node_mem_web    <= 1'b0;
      wbs_node_mem_addr   <= '0;
      wbs_node_mem_wdata  <= '0;
    end else begin
      state_q             <= state_d;
      adr_q               <= adr_d;
      dat_q               <= dat_d;
      we_q                <= we_d;
      qstage_q            <= qstage_d;
      lstage_q            <= lstage_d;
      wbs_ack_o           <= ack_d;
      wbs_dat_o           <= dat_o_d;
      wbs_mode            <= mode_d;
      wbs_debug           <= debug_d;
      wbs_qp_mem_csb0     <= qp_csb_d;
      wbs_qp_mem_web0     <= qp_web_d;
      wbs_qp_mem_addr0    <= qp_addr_d;
      wbs_qp_mem_wpatch0  <= qp_wpatch_d;
      wbs_leaf_mem_csb0   <= leaf_csb_d;
      wbs_leaf_mem_web0   <= leaf_web_d;
      wbs_leaf_mem_addr0  <= leaf_addr_d;
      wbs_leaf_mem_wleaf0 <= leaf_wleaf_d;
      wbs_node_mem_web    <= node_web_d;
      wbs_node_mem_addr   <= node_addr_d;
      wbs_node_mem_wdata  <= node_wdata_d;
    end
  end

endmodule

// File: tb/tb_wbs_ctrl.sv
// Self-checking bench for wbs_ctrl: vector table through a read-data
// scoreboard, plus hand-written reset, drop and back-to-back sequences.
module tb_wbs_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic              stb, cyc, we;
  logic [3:0]        sel;
  logic [31:0]       dat_i, adr;
  logic              ack;
  logic [31:0]       dat_o;
  logic              mode, debug;
  logic              qp_csb, qp_web;
  logic [8:0]        qp_addr;
  logic [54:0]       qp_wpatch, qp_rpatch;
  logic [7:0]        leaf_csb, leaf_web;
  logic [5:0]        leaf_addr;
  logic [63:0]       leaf_wleaf;
  logic [7:0][63:0]  leaf_rleaf;
  logic              node_web;
  logic [31:0]       node_addr, node_wdata, node_rdata;

  wbs_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .wbs_mode(mode), .wbs_debug(debug),
    .wbs_qp_mem_csb0(qp_csb), .wbs_qp_mem_web0(qp_web),
    .wbs_qp_mem_addr0(qp_addr), .wbs_qp_mem_wpatch0(qp_wpatch),
    .wbs_qp_mem_rpatch0(qp_rpatch),
    .wbs_leaf_mem_csb0(leaf_csb), .wbs_leaf_mem_web0(leaf_web),
    .wbs_leaf_mem_addr0(leaf_addr), .wbs_leaf_mem_wleaf0(leaf_wleaf),
    .wbs_leaf_mem_rleaf0(leaf_rleaf),
    .wbs_node_mem_web(node_web), .wbs_node_mem_addr(node_addr),
    .wbs_node_mem_wdata(node_wdata), .wbs_node_mem_rdata(node_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected dat_o values, one per ack
  logic [31:0] sb_q[$];

  always @(negedge clk) begin
    if (ack) begin
      if (sb_q.size() == 0) chk("unexpected_ack", 64'(ack), 64'd0);
      else chk("dat_o_at_ack", 64'(dat_o), 64'(sb_q.pop_front()));
    end
  end

  // Strobe monitor: counts active cycles and records the values seen
  int          qp_cnt, leaf_cnt, node_cnt;
  logic        qp_web_s;
  logic [8:0]  qp_addr_s;
  logic [54:0] qp_wpatch_s;
  logic [7:0]  leaf_csb_s, leaf_web_s;
  logic [5:0]  leaf_addr_s;
  logic [31:0] node_addr_s, node_wdata_s;

  always @(negedge clk) begin
    if (!qp_csb) begin
      qp_cnt++; qp_web_s = qp_web; qp_addr_s = qp_addr; qp_wpatch_s = qp_wpatch;
    end
    if (leaf_csb != 8'hFF) begin
      leaf_cnt++; leaf_csb_s = leaf_csb; leaf_web_s = leaf_web; leaf_addr_s = leaf_addr;
    end
    if (node_web) begin
      node_cnt++; node_addr_s = node_addr; node_wdata_s = node_wdata;
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input bit drop, output int lat);
    sb_q.push_back(exp);
    qp_cnt = 0; leaf_cnt = 0; node_cnt = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    lat = 0;
    if (drop) begin
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      lat = 1;
    end
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ack) break;
    end
    if (!ack) chk("ack_timeout", 64'(ack), 64'd1);
    cyc = 1'b0; stb = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    int          eqp;
    int          eleaf;
    int          enode;
    logic        emode;
    logic        edbg;
  } vec_t;

  vec_t vecs[17];
  int   lat;
  int   acks;
  logic prev_ack, b2b;

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
    dat_i = '0; adr = '0;
    qp_rpatch  = 55'h00_1010_DEAD_BEEF;
    node_rdata = 32'hCAFE_0123;
    for (int b = 0; b < 8; b++)
      leaf_rleaf[b] = {24'h0, 8'(b), 32'hA5A5_0000 | 32'(b)};
    leaf_rleaf[7] = 64'h1100_1010_DEAD_BEEF;

    vecs[0]  = '{1'b1, 32'h3000_0001, 32'd1, 32'd0, 0, 0, 0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 32'h3000_0000, 32'd1, 32'd0, 0, 0, 0, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 32'h3000_0001, 32'd0, 32'd0, 0, 0, 0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'h3000_0000, 32'd0, 32'd1, 0, 0, 0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'h3000_0001, 32'd0, 32'd0, 0, 0, 0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 32'h3100_0002, 32'd0, 32'hDEAD_BEEF, 1, 0, 0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 32'h3100_0003, 32'd0, 32'h0000_1010, 1, 0, 0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 32'h3100_0004, 32'h0123_4567, 32'd0, 0, 0, 0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h3100_0005, 32'h000B_CDEF, 32'd0, 1, 0, 0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 32'h3200_000E, 32'd0, 32'hDEAD_BEEF, 0, 1, 0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h3200_000F, 32'd0, 32'h1100_1010, 0, 1, 0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 32'h3200_0000, 32'd0, 32'hA5A5_0000, 0, 1, 0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 32'h3400_0001, {10'b0, 11'd55, 11'd1}, 32'd0, 0, 0, 1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 32'h3400_0001, 32'd0, 32'hCAFE_0123, 0, 0, 0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 32'h3300_0010, 32'd0, 32'd0, 0, 0, 0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 32'h3500_0000, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 32'h3000_0000, 32'd0, 32'd1, 0, 0, 0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_dat_o", 64'(dat_o), 64'd0);
    chk("rst_mode", 64'(mode), 64'd0);
    chk("rst_debug", 64'(debug), 64'd0);
    chk("rst_qp_strobes", 64'({qp_csb, qp_web}), 64'h3);
    chk("rst_leaf_strobes", 64'({leaf_csb, leaf_web}), 64'hFFFF);
    chk("rst_node_web", 64'(node_web), 64'd0);
    chk("rst_addrs", 64'({qp_addr, leaf_addr, node_addr}), 64'd0);

    foreach (vecs[i]) begin
      xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp, 1'b0, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("v%0d_qp_cnt", i), 64'(qp_cnt), 64'(vecs[i].eqp));
      chk($sformatf("v%0d_leaf_cnt", i), 64'(leaf_cnt), 64'(vecs[i].eleaf));
      chk($sformatf("v%0d_node_cnt", i), 64'(node_cnt), 64'(vecs[i].enode));
      chk($sformatf("v%0d_mode", i), 64'(mode), 64'(vecs[i].emode));
      chk($sformatf("v%0d_debug", i), 64'(debug), 64'(vecs[i].edbg));
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_dat_o_hold", i), 64'(dat_o), 64'(vecs[i].exp));
      if (i == 5) chk("qrd_addr_web", 64'({qp_addr_s, qp_web_s}), 64'({9'd1, 1'b1}));
      if (i == 8) begin
        chk("qwr_addr_web", 64'({qp_addr_s, qp_web_s}), 64'({9'd2, 1'b0}));
        chk("qwr_wpatch", 64'(qp_wpatch_s), 64'({23'h0BCDEF, 32'h0123_4567}));
      end
      if (i == 9) begin
        chk("leaf_csb", 64'(leaf_csb_s), 64'h7F);
        chk("leaf_web", 64'(leaf_web_s), 64'hFF);
        chk("leaf_addr", 64'(leaf_addr_s), 64'd0);
      end
      if (i == 12) begin
        chk("node_addr", 64'(node_addr_s), 64'd1);
        chk("node_wdata", 64'(node_wdata_s), 64'({10'b0, 11'd55, 11'd1}));
      end
    end

    // Leaf write pair on bank 2, leaf address 3
    xfer(1'b1, 32'h3200_0034, 32'h8765_4321, 32'd0, 1'b0, lat);
    chk("lwr_lo_no_access", 64'(leaf_cnt), 64'd0);
    xfer(1'b1, 32'h3200_0035, 32'h0F0F_0F0F, 32'd0, 1'b0, lat);
    chk("lwr_hi_cnt", 64'(leaf_cnt), 64'd1);
    chk("lwr_hi_strobes", 64'({leaf_csb_s, leaf_web_s}), 64'hFBFB);
    chk("lwr_hi_addr", 64'(leaf_addr_s), 64'd3);
    chk("lwr_wleaf", 64'(leaf_wleaf), 64'h0F0F_0F0F_8765_4321);

    // Dropping cyc/stb right after acceptance still completes
    xfer(1'b0, 32'h3200_000F, 32'd0, 32'h1100_1010, 1'b1, lat);
    chk("drop_latency", 64'(lat), 64'd4);

    // Held stb re-triggers every fourth cycle, never back-to-back acks
    repeat (3) sb_q.push_back(32'd0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3300_0000;
    acks = 0; prev_ack = 1'b0; b2b = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ack) acks++;
      if (ack && prev_ack) b2b = 1'b1;
      prev_ack = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("held_ack_count", 64'(acks), 64'd3);
    chk("held_back_to_back", 64'(b2b), 64'd0);
    repeat (6) @(negedge clk);
    chk("held_sb_drained", 64'(sb_q.size()), 64'd0);

    // Stage a query lower half so reset has something to clear
    xfer(1'b1, 32'h3100_0008, 32'h5555_AAAA, 32'd0, 1'b0, lat);

    // Reset during WAIT: transaction abandoned, no ack afterwards
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3100_0002;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("wrst_ack", 64'(ack), 64'd0);
    chk("wrst_dat_o", 64'(dat_o), 64'd0);
    chk("wrst_mode", 64'(mode), 64'd0);
    chk("wrst_qp_strobes", 64'({qp_csb, qp_web}), 64'h3);
    chk("wrst_addrs", 64'({qp_addr, leaf_addr, node_addr}), 64'd0);
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("wrst_no_ack", 64'(acks), 64'd0);

    // Upper write after reset must see a cleared staging register
    xfer(1'b1, 32'h3100_0001, 32'h0000_0007, 32'd0, 1'b0, lat);
    chk("post_rst_wpatch", 64'(qp_wpatch_s), 64'({23'h7, 32'h0}));
    chk("post_rst_qp_addr", 64'(qp_addr_s), 64'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
